counter_bank: RTL and testbench
===============================

// Module: counter_bank
// PURPOSE
//  Parametrised bank of N_CH trigger-controlled counters, successor to the single up/down debug counter.
//  Adds per-channel modes, load, wrap/saturate, terminal-count pulses and coherent snapshot capture.
//  Snapshots let the host read wide counts through 16-bit WireOut halves without tearing.
//  Sits between okTriggerIn/okWireIn endpoints and okWireOut endpoints, all in the sys_clk domain.
// PARAMETERS
//  N_CH   4   number of counter channels (1..16)
//  WIDTH  32  counter width in bits (8..64)
//  SEQ_W  8   width of the snapshot sequence number
// PORTS
//  sys_clk     in   1           single clock for all logic
//  reset       in   1           synchronous, active-high; clears all state
//  trig_clr    in   N_CH        one-cycle pulse per channel: clear that channel's count to 0
//  trig_load   in   N_CH        one-cycle pulse: count <= load_val slice
//  trig_up     in   N_CH        one-cycle pulse: step +1
//  trig_down   in   N_CH        one-cycle pulse: step -1
//  load_val    in   N_CH*WIDTH  load values; channel i = [i*WIDTH +: WIDTH]
//  mode        in   N_CH*2      per channel: 00 MANUAL, 01 RUN_UP, 10 RUN_DOWN, 11 HOLD
//  sat_en      in   N_CH        1 = saturate at 0 / all-ones; 0 = wrap
//  snap_trig   in   1           one-cycle pulse: capture all counts
//  count       out  N_CH*WIDTH  live counts
//  tc_pulse    out  N_CH        one-cycle terminal-count pulse per channel
//  snap_count  out  N_CH*WIDTH  captured counts
//  snap_seq    out  SEQ_W       increments on every capture, wraps modulo 2^SEQ_W
// BEHAVIOUR
//  - Reset values: count, tc_pulse, snap_count and snap_seq are all 0.
//    mode/sat_en/load_val are sampled and need no reset.
//  - Per-channel priority, evaluated each cycle, highest first:
//    1. trig_clr -> 0
//    2. trig_load -> load_val
//    3. HOLD -> no change
//    4. step = (+1 if trig_up or mode==RUN_UP) + (-1 if trig_down or mode==RUN_DOWN)
//  - Net step 0 (e.g. trig_up and trig_down together, or trig_down while RUN_UP) leaves the count unchanged.
//  - Step arithmetic is modulo 2^WIDTH when sat_en=0.
//    When sat_en=1: +1 at all-ones and -1 at 0 leave the count unchanged.
//  - tc_pulse[i] is registered and asserts in the same cycle the new count becomes visible:
//    - wrap: on a step all-ones->0 or 0->all-ones;
//    - saturate: on a step that makes count reach all-ones (up) or 0 (down) from another value;
//    - a held step at a limit gives no pulse; clear and load never pulse.
//  - In RUN_UP/RUN_DOWN, tc_pulse repeats every 2^WIDTH cycles (wrap mode); in saturate mode it fires once.
//  - snap_trig: snap_count <= the count register values of that same cycle, i.e. the pre-update values.
//    snap_seq increments in the same edge. Latency from snap_trig to new snap_count is 1 cycle.
//  - snap_trig coincident with a channel update captures the OLD value; the update still takes effect.
//  - snap_trig coincident with reset: reset wins and snap_seq stays 0.
//  - Channels are fully independent; no cross-channel carry.
//  - Mode change takes effect on the next edge with no pipeline.
// STRUCTURE
//  - Package counter_bank_pkg holds the MODE_MANUAL/RUN_UP/RUN_DOWN/HOLD 2-bit constants and the
//    channel-slice helper function.
//  - Sub-module counter_channel (WIDTH) holds one count register plus tc logic, instantiated N_CH times via generate.
//  - The snapshot registers and snap_seq live in the top.
// TESTING
//  1. Reset, then N_CH=4, WIDTH=8, all MANUAL. Pulse trig_up[0] 3x, trig_down[1] 1x.
//     Expect count0=3, count1=0xFF and tc_pulse[1]=1 for one cycle.
//  2. Ch2 sat_en=1, load 0xFE, mode RUN_UP for 5 cycles.
//     Expect 0xFF after 1 cycle, held at 0xFF, exactly one tc_pulse[2].
//  3. trig_up[0] and trig_down[0] in the same cycle at count 5 -> stays 5, no tc.
//     trig_clr and trig_load in the same cycle -> count=0.
//  4. Ch3 RUN_DOWN with snap_trig when count3=0x10.
//     Expect snap_count3=0x10, count3=0x0F next cycle, snap_seq 0->1.
//     Then 256 more snaps -> snap_seq wraps back to 1.
//  5. Ch0 RUN_UP, assert reset for 1 cycle mid-count -> all outputs 0 on the next cycle, counting resumes after.
//  6. WIDTH=32 wrap: load 0xFFFFFFFF, trig_up -> count=0 with tc_pulse; HOLD then ignores trig_up.

Source files
------------

// File: rtl/counter_bank_pkg.sv
// Shared mode encodings and slice helper for the counter bank.
package counter_bank_pkg;

  localparam logic [1:0] MODE_MANUAL   = 2'b00;
  localparam logic [1:0] MODE_RUN_UP   = 2'b01;
  localparam logic [1:0] MODE_RUN_DOWN = 2'b10;
  localparam logic [1:0] MODE_HOLD     = 2'b11;

  // Low bit index of channel ch inside a flat bus of width-bit slices.
  function automatic int unsigned ch_lo(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/counter_channel.sv
// One counter channel: count register with clear/load/step priority and a terminal-count pulse.
module counter_channel
  import counter_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic             up,
  input  logic             down,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  input  logic             sat_en,
  output logic [WIDTH-1:0] count,
  output logic             tc_pulse
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             inc, dec;

  assign inc = up | (mode == MODE_RUN_UP);
  assign dec = down | (mode == MODE_RUN_DOWN);

  // Next count and terminal-count decision, highest priority first.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (clr) begin
      count_d = ZERO;
    end else if (load) begin
      count_d = load_val;
    end else if (mode == MODE_HOLD) begin
      count_d = count_q;
    end else if (inc && !dec) begin
      if (count_q == ALL_ONES) begin
        // Saturated: stay put silently; wrapping: roll over and pulse.
        if (!sat_en) begin
          count_d = ZERO;
          tc_d    = 1'b1;
        end
      end else begin
        count_d = count_q + ONE;
        tc_d    = sat_en && (count_q == ALL_ONES - ONE);
      end
    end else if (dec && !inc) begin
      if (count_q == ZERO) begin
        if (!sat_en) begin
          count_d = ALL_ONES;
          tc_d    = 1'b1;
        end
      end else begin
        count_d = count_q - ONE;
        tc_d    = sat_en && (count_q == ONE);
      end
    end
  end

  // Count and pulse registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      count_q <= ZERO;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count    = count_q;
  assign tc_pulse = tc_q;

endmodule

// File: rtl/counter_bank.sv
// Bank of independent trigger-controlled counters with coherent snapshot capture.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEQ_W = 8
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       trig_clr,
  input  logic [N_CH-1:0]       trig_load,
  input  logic [N_CH-1:0]       trig_up,
  input  logic [N_CH-1:0]       trig_down,
  input  logic [N_CH*WIDTH-1:0] load_val,
  input  logic [N_CH*2-1:0]     mode,
  input  logic [N_CH-1:0]       sat_en,
  input  logic                  snap_trig,
  output logic [N_CH*WIDTH-1:0] count,
  output logic [N_CH-1:0]       tc_pulse,
  output logic [N_CH*WIDTH-1:0] snap_count,
  output logic [SEQ_W-1:0]      snap_seq
);

  localparam logic [SEQ_W-1:0] SEQ_ONE = {{(SEQ_W-1){1'b0}}, 1'b1};

  logic [N_CH*WIDTH-1:0] snap_q;
  logic [SEQ_W-1:0]      seq_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    counter_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .sys_clk  (sys_clk),
      .reset    (reset),
      .clr      (trig_clr[i]),
      .load     (trig_load[i]),
      .up       (trig_up[i]),
      .down     (trig_down[i]),
      .load_val (load_val[ch_lo(i, WIDTH) +: WIDTH]),
      .mode     (mode[ch_lo(i, 2) +: 2]),
      .sat_en   (sat_en[i]),
      .count    (count[ch_lo(i, WIDTH) +: WIDTH]),
      .tc_pulse (tc_pulse[i])
    );
  end

  // Capture the registered counts (pre-update values) and bump the sequence number.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      snap_q <= '0;
      seq_q  <= '0;
    end else if (snap_trig) begin
      snap_q <= count;
      seq_q  <= seq_q + SEQ_ONE;
    end
  end

  assign snap_count = snap_q;
  assign snap_seq   = seq_q;

endmodule

// File: tb/tb_counter_bank.sv
// Directed bench for counter_bank: an 8-bit 4-channel instance plus a 32-bit 1-channel instance.
module tb_counter_bank;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned WW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [N-1:0]   trig_clr, trig_load, trig_up, trig_down, sat_en;
  logic [N*W-1:0] load_val;
  logic [2*N-1:0] mode;
  logic           snap_trig;
  logic [N*W-1:0] count, snap_count;
  logic [N-1:0]   tc_pulse;
  logic [7:0]     snap_seq;

  logic [0:0]    w_clr, w_load, w_up, w_down, w_sat, w_tc;
  logic [WW-1:0] w_load_val, w_count, w_snap_count;
  logic [1:0]    w_mode;
  logic          w_snap;
  logic [7:0]    w_snap_seq;

  counter_bank #(.N_CH(N), .WIDTH(W), .SEQ_W(8)) dut (
    .sys_clk    (clk),
    .reset      (reset),
    .trig_clr   (trig_clr),
    .trig_load  (trig_load),
    .trig_up    (trig_up),
    .trig_down  (trig_down),
    .load_val   (load_val),
    .mode       (mode),
    .sat_en     (sat_en),
    .snap_trig  (snap_trig),
    .count      (count),
    .tc_pulse   (tc_pulse),
    .snap_count (snap_count),
    .snap_seq   (snap_seq)
  );

  counter_bank #(.N_CH(1), .WIDTH(WW), .SEQ_W(8)) dut_w (
    .sys_clk    (clk),
    .reset      (reset),
    .trig_clr   (w_clr),
    .trig_load  (w_load),
    .trig_up    (w_up),
    .trig_down  (w_down),
    .load_val   (w_load_val),
    .mode       (w_mode),
    .sat_en     (w_sat),
    .snap_trig  (w_snap),
    .count      (w_count),
    .tc_pulse   (w_tc),
    .snap_count (w_snap_count),
    .snap_seq   (w_snap_seq)
  );

  typedef struct {
    string       name;
    logic [3:0]  clr, load, up, down, sat;
    logic [7:0]  mode;
    logic [31:0] ld;
    logic        snap;
    logic [31:0] e_count;
    logic [3:0]  e_tc;
    logic [31:0] e_snap;
    logic [7:0]  e_seq;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string name, input logic [3:0] clr, input logic [3:0] load,
                              input logic [3:0] up, input logic [3:0] down,
                              input logic [3:0] sat, input logic [7:0] md,
                              input logic [31:0] ld, input logic snap,
                              input logic [31:0] e_count, input logic [3:0] e_tc,
                              input logic [31:0] e_snap, input logic [7:0] e_seq);
    vec_t v;
    v.name = name; v.clr = clr; v.load = load; v.up = up; v.down = down; v.sat = sat;
    v.mode = md; v.ld = ld; v.snap = snap; v.e_count = e_count; v.e_tc = e_tc;
    v.e_snap = e_snap; v.e_seq = e_seq;
    return v;
  endfunction

  initial begin
    // Counts are packed {ch3, ch2, ch1, ch0}, one byte each.
    vecs.push_back(mk("up0_1",          0, 0, 1, 0, 0, 8'h00, 32'h0,  0, 32'h00000001, 0, 0, 0));
    vecs.push_back(mk("up0_2_down1",    0, 0, 1, 2, 0, 8'h00, 32'h0,  0, 32'h0000FF02, 2, 0, 0));
    vecs.push_back(mk("up0_3",          0, 0, 1, 0, 0, 8'h00, 32'h0,  0, 32'h0000FF03, 0, 0, 0));
    vecs.push_back(mk("load2_fe",       0, 4, 0, 0, 4, 8'h00, 32'h00FE0000, 0,
                      32'h00FEFF03, 0, 0, 0));
    vecs.push_back(mk("run_up2_sat",    0, 0, 0, 0, 4, 8'h10, 32'h0,  0, 32'h00FFFF03, 4, 0, 0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk("run_up2_held", 0, 0, 0, 0, 4, 8'h10, 32'h0,  0, 32'h00FFFF03, 0, 0, 0));
    vecs.push_back(mk("load0_5",        0, 1, 0, 0, 0, 8'h00, 32'h5,  0, 32'h00FFFF05, 0, 0, 0));
    vecs.push_back(mk("up_down_cancel", 0, 0, 1, 1, 0, 8'h00, 32'h0,  0, 32'h00FFFF05, 0, 0, 0));
    vecs.push_back(mk("clr_beats_load", 1, 1, 0, 0, 0, 8'h00, 32'h77, 0, 32'h00FFFF00, 0, 0, 0));
    vecs.push_back(mk("load3_12",       0, 8, 0, 0, 0, 8'h00, 32'h12000000, 0,
                      32'h12FFFF00, 0, 0, 0));
    vecs.push_back(mk("run_dn3_a",      0, 0, 0, 0, 0, 8'h80, 32'h0,  0, 32'h11FFFF00, 0, 0, 0));
    vecs.push_back(mk("run_dn3_b",      0, 0, 0, 0, 0, 8'h80, 32'h0,  0, 32'h10FFFF00, 0, 0, 0));
    vecs.push_back(mk("snap_at_10",     0, 0, 0, 0, 0, 8'h80, 32'h0,  1, 32'h0FFFFF00, 0,
                      32'h10FFFF00, 1));
    vecs.push_back(mk("run_dn3_post",   0, 0, 0, 0, 0, 8'h80, 32'h0,  0, 32'h0EFFFF00, 0,
                      32'h10FFFF00, 1));
    vecs.push_back(mk("sat_down_hold0", 0, 0, 0, 1, 1, 8'h00, 32'h0,  0, 32'h0EFFFF00, 0,
                      32'h10FFFF00, 1));
    vecs.push_back(mk("sat_up_hold1",   0, 0, 2, 0, 2, 8'h00, 32'h0,  0, 32'h0EFFFF00, 0,
                      32'h10FFFF00, 1));
    vecs.push_back(mk("wrap_up1",       0, 0, 2, 0, 0, 8'h00, 32'h0,  0, 32'h0EFF0000, 2,
                      32'h10FFFF00, 1));
    vecs.push_back(mk("load3_01",       0, 8, 0, 0, 0, 8'h00, 32'h01000000, 0, 32'h01FF0000, 0,
                      32'h10FFFF00, 1));
    vecs.push_back(mk("sat_down3_to0",  0, 0, 0, 8, 8, 8'h00, 32'h0,  0, 32'h00FF0000, 8,
                      32'h10FFFF00, 1));
    vecs.push_back(mk("down_vs_runup0", 0, 0, 0, 1, 0, 8'h01, 32'h0,  0, 32'h00FF0000, 0,
                      32'h10FFFF00, 1));

    trig_clr = '0; trig_load = '0; trig_up = '0; trig_down = '0; sat_en = '0;
    load_val = '0; mode = '0; snap_trig = 1'b0;
    w_clr = '0; w_load = '0; w_up = '0; w_down = '0; w_sat = '0;
    w_load_val = '0; w_mode = '0; w_snap = 1'b0;

    reset = 1'b1;
    tick();
    tick();
    check("reset_count",    count,      0);
    check("reset_tc",       tc_pulse,   0);
    check("reset_snap",     snap_count, 0);
    check("reset_seq",      snap_seq,   0);
    check("reset_w_count",  w_count,    0);
    reset = 1'b0;

    // Table-driven section.
    foreach (vecs[n]) begin
      trig_clr  = vecs[n].clr;
      trig_load = vecs[n].load;
      trig_up   = vecs[n].up;
      trig_down = vecs[n].down;
      sat_en    = vecs[n].sat;
      mode      = vecs[n].mode;
      load_val  = vecs[n].ld;
      snap_trig = vecs[n].snap;
      tick();
      check({vecs[n].name, "_count"}, count,      vecs[n].e_count);
      check({vecs[n].name, "_tc"},    tc_pulse,   vecs[n].e_tc);
      check({vecs[n].name, "_snap"},  snap_count, vecs[n].e_snap);
      check({vecs[n].name, "_seq"},   snap_seq,   vecs[n].e_seq);
    end
    trig_clr = '0; trig_load = '0; trig_up = '0; trig_down = '0; sat_en = '0;
    mode = '0; load_val = '0; snap_trig = 1'b0;

    // 256 captures of static counts: sequence wraps back to where it started.
    snap_trig = 1'b1;
    tick();
    check("snap_seq_2", snap_seq, 2);
    for (int k = 0; k < 255; k++) tick();
    snap_trig = 1'b0;
    check("snap_seq_wrap",  snap_seq,   1);
    check("snap_static",    snap_count, 32'h00FF0000);

    // Reset mid-count wins over a coincident snapshot; counting resumes afterwards.
    mode = 8'h01;
    tick(); tick(); tick();
    check("run_up0_3", count, 32'h00FF0003);
    reset     = 1'b1;
    snap_trig = 1'b1;
    tick();
    check("mid_reset_count", count,      0);
    check("mid_reset_tc",    tc_pulse,   0);
    check("mid_reset_snap",  snap_count, 0);
    check("mid_reset_seq",   snap_seq,   0);
    reset     = 1'b0;
    snap_trig = 1'b0;
    tick();
    check("resume_count", count, 32'h00000001);
    check("resume_seq",   snap_seq, 0);
    mode = '0;

    // 32-bit wrap with terminal count, then HOLD ignores triggers.
    w_load     = 1'b1;
    w_load_val = 32'hFFFFFFFF;
    tick();
    check("w_load", w_count, 32'hFFFFFFFF);
    check("w_load_tc", w_tc, 0);
    w_load = 1'b0;
    w_up   = 1'b1;
    tick();
    check("w_wrap_count", w_count, 0);
    check("w_wrap_tc",    w_tc,    1);
    w_up = 1'b0;
    tick();
    check("w_tc_one_cycle", w_tc, 0);
    w_mode = 2'b11;
    w_up   = 1'b1;
    tick();
    check("w_hold_count", w_count, 0);
    check("w_hold_tc",    w_tc,    0);
    w_up   = 1'b0;
    w_mode = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
